// File: rtl/mul_pkg.sv
// Shared defaults and pipeline-split helper for the pipelined multiplier.
package mul_pkg;

  localparam int MUL_WIDTH  = 32;
  localparam int MUL_STAGES = 3;
  localparam int MUL_TAG_W  = 5;
  localparam int MUL_LEVELS = $clog2(MUL_WIDTH);

  // Number of adder-tree levels finished once stage s has registered its result.
  // Stage s evaluates levels lvl_end(s-1) .. lvl_end(s)-1, spreading them evenly.
  function automatic int lvl_end(input int s, input int levels, input int stages);
    return (s < 0) ? 0 : (levels * (s + 1)) / stages;
  endfunction

endpackage

// File: rtl/mul_pp_reduce.sv
// One adder-tree level: sums adjacent pairs of partial products.
module mul_pp_reduce #(
  parameter int N  = 2,
  parameter int PW = 64
) (
  input  logic [N-1:0][PW-1:0]   in_pp,
  output logic [N/2-1:0][PW-1:0] out_pp
);

  always_comb begin
    for (int i = 0; i < N / 2; i++) begin
      out_pp[i] = in_pp[2*i] + in_pp[2*i+1];
    end
  end

endmodule

// File: rtl/mul_pipe.sv
// Fully pipelined signed/unsigned multiplier with valid/ready handshake,
// global stall on output backpressure and single-cycle flush.
module mul_pipe
  import mul_pkg::*;
#(
  parameter int WIDTH  = MUL_WIDTH,
  parameter int STAGES = MUL_STAGES,
  parameter int TAG_W  = MUL_TAG_W
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_prod,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy
);

  localparam int PW     = 2 * WIDTH;
  localparam int LEVELS = $clog2(WIDTH);
  localparam int NPP    = 1 << LEVELS;

  // ---------------------------------------------------------------------------
  // Valid / stall / flush control
  // ---------------------------------------------------------------------------
  logic              stall;
  logic              accept;
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;

  assign stall     = v_q[STAGES-1] && !out_ready;
  assign in_ready  = !stall && !flush;
  assign accept    = in_valid && in_ready;
  assign v_d       = (v_q << 1) | STAGES'(accept);
  assign out_valid = v_q[STAGES-1];
  assign busy      = |v_q;

  // NOTE: state uses <= so each stage samples its predecessor's pre-edge value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v_q <= '0;
    end else if (flush) begin
      v_q <= '0;
    end else if (!stall) begin
      v_q <= v_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand conditioning: multiply magnitudes, fix the sign at the end.
  // |-2^(WIDTH-1)| = 2^(WIDTH-1) still fits WIDTH bits when read as unsigned.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]         mag_a;
  logic [WIDTH-1:0]         mag_b;
  logic                     in_neg;
  logic [NPP-1:0][PW-1:0]   pp_vec;

  assign mag_a  = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
  assign mag_b  = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
  assign in_neg = in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);

  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    pp_vec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (mag_b[i]) pp_vec[i] = PW'(mag_a) << i;
    end
  end

  // ---------------------------------------------------------------------------
  // Adder tree split across stages; each stage narrows the live vector.
  // ---------------------------------------------------------------------------
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO   = lvl_end(s - 1, LEVELS, STAGES);
    localparam int HI   = lvl_end(s, LEVELS, STAGES);
    localparam int CIN  = NPP >> LO;
    localparam int COUT = NPP >> HI;

    logic [CIN-1:0][PW-1:0]  sin;
    logic [COUT-1:0][PW-1:0] sout;
    logic                    neg_in;
    logic [TAG_W-1:0]        tag_in;

    if (s == 0) begin : g_src
      assign sin    = pp_vec;
      assign neg_in = in_neg;
      assign tag_in = in_tag;
    end else begin : g_src
      assign sin    = g_stage[s-1].g_reg.data_q;
      assign neg_in = g_stage[s-1].g_reg.neg_q;
      assign tag_in = g_stage[s-1].g_reg.tag_q;
    end

    for (genvar l = LO; l < HI; l++) begin : g_lvl
      localparam int N = NPP >> l;
      logic [N-1:0][PW-1:0]   lin;
      logic [N/2-1:0][PW-1:0] lout;

      if (l == LO) begin : g_in
        assign lin = sin;
      end else begin : g_in
        assign lin = g_lvl[l-1].lout;
      end

      mul_pp_reduce #(.N(N), .PW(PW)) u_reduce (
        .in_pp  (lin),
        .out_pp (lout)
      );
    end

    if (HI > LO) begin : g_out
      assign sout = g_lvl[HI-1].lout;
    end else begin : g_out
      assign sout = sin;
    end

    if (s < STAGES - 1) begin : g_reg
      logic [COUT-1:0][PW-1:0] data_q;
      logic                    neg_q;
      logic [TAG_W-1:0]        tag_q;

      // NOTE: datapath flops carry no reset; the valid bits alone say what is live.
      always_ff @(posedge clk) begin
        if (!stall) begin
          data_q <= sout;
          neg_q  <= neg_in;
          tag_q  <= tag_in;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register: sign correction on the fully reduced sum.
  // ---------------------------------------------------------------------------
  logic [PW-1:0]    fin_sum;
  logic             fin_neg;
  logic [TAG_W-1:0] fin_tag;

  assign fin_sum = g_stage[STAGES-1].sout[0];
  assign fin_neg = g_stage[STAGES-1].neg_in;
  assign fin_tag = g_stage[STAGES-1].tag_in;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_prod <= '0;
      out_tag  <= '0;
    end else if (!stall && v_d[STAGES-1]) begin
      out_prod <= fin_neg ? -fin_sum : fin_sum;
      out_tag  <= fin_tag;
    end
  end

endmodule

// File: tb/tb_mul_pipe.sv
// Self-checking bench for mul_pipe: directed corner products, throughput,
// backpressure, flush and asynchronous reset against a queue-based model.
module tb_mul_pipe;

  localparam int W = 32;
  localparam int S = 3;
  localparam int T = 5;

  logic           clk;
  logic           resetn;
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic           in_signed;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic [T-1:0]   in_tag;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_prod;
  logic [T-1:0]   out_tag;
  logic           busy;

  typedef struct {
    logic [2*W-1:0] prod;
    logic [T-1:0]   tag;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  mul_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(T)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: plain integer multiplication of the extended operands.
  function automatic logic [2*W-1:0] model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    if (sgn) return sa * sb;
    return ua * ub;
  endfunction

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return W'(1);
      2:       return '1;
      3:       return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom());
    endcase
  endfunction

  // Applies inputs for one cycle (called just after a falling edge), samples the
  // handshake just before the rising edge, then waits for the next falling edge.
  task automatic drive(input logic v, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [T-1:0] tag, input logic ordy, input logic fl,
                       output logic acc, output logic took, output logic [2*W-1:0] gp,
                       output logic [T-1:0] gt);
    exp_t e;
    in_valid  = v;
    in_signed = sgn;
    in_a      = a;
    in_b      = b;
    in_tag    = tag;
    out_ready = ordy;
    flush     = fl;
    #1;
    acc  = v && in_ready;
    took = out_valid && ordy;
    gp   = out_prod;
    gt   = out_tag;
    if (acc) begin
      e.prod = model(sgn, a, b);
      e.tag  = tag;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    flush = 1'b0; in_valid = 1'b0; in_signed = 1'b0;
    in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    #2 resetn = 1'b0;
    #1;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (out_prod !== '0)    begin errors++; $display("FAIL reset_out_prod: got %h, required 0", out_prod); end
    if (out_tag !== '0)     begin errors++; $display("FAIL reset_out_tag: got %0d, required 0", out_tag); end
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic           ts [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [W-1:0]   ta [4] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFD};
    logic [W-1:0]   tb [4] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'h0000_0007};
    logic [T-1:0]   tt [4] = '{5'd3, 5'd9, 5'd17, 5'd31};
    logic [2*W-1:0] tp [4] = '{64'hFFFF_FFFE_0000_0001, 64'h4000_0000_0000_0000,
                               64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFEB};
    logic acc, took;
    logic [2*W-1:0] gp;
    logic [T-1:0] gt;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, ts[k], ta[k], tb[k], tt[k], 1'b1, 1'b0, acc, took, gp, gt);
      checks++;
      if (acc !== 1'b1) begin errors++; $display("FAIL directed_accept op%0d: accepted=%b, required 1", k, acc); end
      for (int e = 1; e <= S; e++) begin
        checks++;
        if (out_valid !== (e == S)) begin
          errors++;
          $display("FAIL directed_latency op%0d edge%0d: out_valid=%b, required %b", k, e, out_valid, (e == S));
        end
        if (e < S) drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, acc, took, gp, gt);
      end
      checks += 2;
      if (out_prod !== tp[k]) begin errors++; $display("FAIL directed_prod op%0d: got %h, required %h", k, out_prod, tp[k]); end
      if (out_tag !== tt[k])  begin errors++; $display("FAIL directed_tag op%0d: got %0d, required %0d", k, out_tag, tt[k]); end
      drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, acc, took, gp, gt);
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    logic acc, took;
    logic [2*W-1:0] gp;
    logic [T-1:0] gt;
    exp_t e;
    int first_c = -1, last_c = -1, n_res = 0;
    for (int c = 0; c < 4 + S + 3; c++) begin
      if (c < 4) drive(1'b1, (c % 2) == 0, rand_op(), rand_op(), T'(c), 1'b1, 1'b0, acc, took, gp, gt);
      else       drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, acc, took, gp, gt);
      if (took) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        n_res++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_result: got prod=%h tag=%0d, required no result", gp, gt);
        end else begin
          e = exp_q.pop_front();
          if (gp !== e.prod || gt !== e.tag) begin
            errors++; $display("FAIL b2b_result: got prod=%h tag=%0d, required prod=%h tag=%0d", gp, gt, e.prod, e.tag);
          end
        end
      end
    end
    checks += 3;
    if (n_res != 4)              begin errors++; $display("FAIL b2b_count: got %0d results, required 4", n_res); end
    if (first_c != S)            begin errors++; $display("FAIL b2b_first: first result in cycle %0d, required %0d", first_c, S); end
    if (last_c - first_c != 3)   begin errors++; $display("FAIL b2b_gapless: span %0d cycles, required 3", last_c - first_c); end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic acc, took;
    logic [2*W-1:0] gp;
    logic [T-1:0] gt;
    exp_t e;
    int n_acc = 0, n_res = 0;
    for (int c = 0; c < S; c++) begin
      drive(1'b1, $urandom_range(0, 1), rand_op(), rand_op(), T'(10 + c), 1'b0, 1'b0, acc, took, gp, gt);
      if (acc) n_acc++;
    end
    checks++;
    if (n_acc != S) begin errors++; $display("FAIL bp_fill: accepted %0d, required %0d", n_acc, S); end
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 1'b0, rand_op(), rand_op(), T'(20 + c), 1'b0, 1'b0, acc, took, gp, gt);
      checks += 3;
      if (acc !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle%0d: accepted=%b, required 0", c, acc); end
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid cycle%0d: got %b, required 1", c, out_valid); end
      if (exp_q.size() == 0 || gp !== exp_q[0].prod || gt !== exp_q[0].tag) begin
        errors++; $display("FAIL bp_hold cycle%0d: got prod=%h tag=%0d, required head of %0d queued results", c, gp, gt, exp_q.size());
      end
    end
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      drive(1'b0, 1'b0, '0, '0, '0, $urandom_range(0, 1), 1'b0, acc, took, gp, gt);
      if (took) begin
        n_res++;
        e = exp_q.pop_front();
        checks++;
        if (gp !== e.prod || gt !== e.tag) begin
          errors++; $display("FAIL bp_drain: got prod=%h tag=%0d, required prod=%h tag=%0d", gp, gt, e.prod, e.tag);
        end
      end
    end
    checks += 2;
    if (n_res != S) begin errors++; $display("FAIL bp_drain_count: got %0d results, required %0d", n_res, S); end
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, acc, took, gp, gt);
    if (took || exp_q.size() != 0) begin
      errors++; $display("FAIL bp_no_dup: extra result=%b, %0d results still expected", took, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    logic acc, took;
    logic [2*W-1:0] gp;
    logic [T-1:0] gt;
    exp_t e;
    for (int c = 0; c < 300 || (exp_q.size() > 0 && c < 340); c++) begin
      if (c < 300)
        drive($urandom_range(0, 9) < 7, $urandom_range(0, 1), rand_op(), rand_op(), T'($urandom()),
              $urandom_range(0, 9) < 6, 1'b0, acc, took, gp, gt);
      else
        drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, acc, took, gp, gt);
      if (took) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_result cycle%0d: got prod=%h tag=%0d, required no result", c, gp, gt);
        end else begin
          e = exp_q.pop_front();
          if (gp !== e.prod || gt !== e.tag) begin
            errors++; $display("FAIL rand_result cycle%0d: got prod=%h tag=%0d, required prod=%h tag=%0d", c, gp, gt, e.prod, e.tag);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rand_drain: %0d results missing, required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_flush();
    logic acc, took;
    logic [2*W-1:0] gp;
    logic [T-1:0] gt;
    int n_acc = 0, n_res = 0;
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b0, rand_op(), rand_op(), T'(c + 1), 1'b1, 1'b0, acc, took, gp, gt);
      if (acc) n_acc++;
    end
    drive(1'b1, 1'b1, 32'd7, 32'd9, 5'd30, 1'b1, 1'b1, acc, took, gp, gt);
    checks += 4;
    if (n_acc != 2)         begin errors++; $display("FAIL flush_setup: accepted %0d, required 2", n_acc); end
    if (acc !== 1'b0)       begin errors++; $display("FAIL flush_in_ready: accepted=%b, required 0", acc); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL flush_busy: got %b, required 0", busy); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b, required 0", out_valid); end
    exp_q.delete();
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, acc, took, gp, gt);
      if (took) n_res++;
    end
    checks++;
    if (n_res != 0) begin errors++; $display("FAIL flush_discard: got %0d results, required 0", n_res); end
    drive(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 5'd12, 1'b1, 1'b0, acc, took, gp, gt);
    for (int c = 0; c < 10 && !took; c++) drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, acc, took, gp, gt);
    checks++;
    if (!took || gp !== 64'hFFFF_FFFF_FFFF_FFFE || gt !== 5'd12) begin
      errors++; $display("FAIL flush_recover: result=%b prod=%h tag=%0d, required prod=fffffffffffffffe tag=12", took, gp, gt);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    logic acc, took;
    logic [2*W-1:0] gp;
    logic [T-1:0] gt;
    int n_res = 0;
    for (int c = 0; c < S; c++) drive(1'b1, 1'b1, rand_op(), rand_op(), T'(c), 1'b1, 1'b0, acc, took, gp, gt);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_setup: out_valid=%b, required 1", out_valid); end
    #2 resetn = 1'b0;
    #1;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b, required 0", out_valid); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
    exp_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b, required 1", in_ready); end
    drive(1'b1, 1'b0, 32'd5, 32'd6, 5'd7, 1'b1, 1'b0, acc, took, gp, gt);
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, acc, took, gp, gt);
      if (took) begin
        n_res++;
        checks++;
        if (gp !== 64'd30 || gt !== 5'd7) begin
          errors++; $display("FAIL rstmid_result: got prod=%h tag=%0d, required prod=30 tag=7", gp, gt);
        end
      end
    end
    checks++;
    if (n_res != 1) begin errors++; $display("FAIL rstmid_count: got %0d results, required 1", n_res); end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
